// File: rtl/spi_alu_pwm_ctrl_pkg.sv
// Shared types and sizing helpers for the SPI-driven ALU/PWM controller.
package ctrl_pkg;

    typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, AND = 2'b10, OR = 2'b11} alu_op_t;

    typedef enum logic [1:0] {IDLE, SHIFT, EXEC, WRITE} state_t;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic s;
    } flags_t;

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int frame_len(input int width, input int channels);
        return 2 + ch_width(channels) + 2 * width;
    endfunction

endpackage

// File: rtl/spi_alu_pwm_ctrl_pwm_bank.sv
// Shared free-running counter with per-channel shadow/active duty registers.
module pwm_bank
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CHANNELS = 2,
    localparam int CH_W = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [CH_W-1:0]     ch,
    input  logic [WIDTH-1:0]    duty,
    output logic [CHANNELS-1:0] pwm_out
);

    logic [WIDTH-1:0] cnt_reg;
    logic             wrap;

    assign wrap = (cnt_reg == '1);

    always_ff @(posedge clk) begin
        if (rst) cnt_reg <= '0;
        else     cnt_reg <= cnt_reg + 1'b1;
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] shadow_reg;
            logic [WIDTH-1:0] active_reg;
            logic             pwm_reg;

            // A write landing on the wrap edge is seen only at the following wrap.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                    pwm_reg    <= 1'b0;
                end else begin
                    if (wrap) active_reg <= shadow_reg;
                    if (we && ch == CH_W'(gi)) shadow_reg <= duty;
                    pwm_reg <= (cnt_reg < active_reg);
                end
            end

            assign pwm_out[gi] = pwm_reg;
        end
    endgenerate

endmodule

// File: rtl/spi_alu_pwm_ctrl.sv
// SPI slave front end, command FSM and ALU feeding a bank of PWM channels.
module spi_alu_pwm_ctrl
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CHANNELS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SCLK,
    input  logic                SS,
    input  logic                MOSI,
    output logic                MISO,
    output logic [3:0]          flags,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                frame_ok,
    output logic                frame_err,
    output logic                busy
);

    localparam int CH_W  = ch_width(CHANNELS);
    localparam int F     = frame_len(WIDTH, CHANNELS);
    localparam int CNT_W = $clog2(F + 2);
    localparam int RB_W  = 4 + WIDTH;

    // Bits [1:0] synchronise, bit [2] is the previous value for edge detection.
    logic [2:0] sclk_pipe_reg, ss_pipe_reg;
    logic [1:0] mosi_pipe_reg;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_pipe_reg <= '0;
            ss_pipe_reg   <= '0;
            mosi_pipe_reg <= '0;
        end else begin
            sclk_pipe_reg <= {sclk_pipe_reg[1:0], SCLK};
            ss_pipe_reg   <= {ss_pipe_reg[1:0], SS};
            mosi_pipe_reg <= {mosi_pipe_reg[0], MOSI};
        end
    end

    assign sclk_rise = sclk_pipe_reg[1] & ~sclk_pipe_reg[2];
    assign sclk_fall = ~sclk_pipe_reg[1] & sclk_pipe_reg[2];
    assign ss_rise   = ss_pipe_reg[1] & ~ss_pipe_reg[2];
    assign ss_fall   = ~ss_pipe_reg[1] & ss_pipe_reg[2];
    assign mosi_bit  = mosi_pipe_reg[1];

    state_t             state_reg;
    logic [F-1:0]       mosi_sr_reg, miso_sr_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [WIDTH-1:0]   result_reg, last_result_reg;
    flags_t             pend_flags_reg, flags_reg;
    logic               frame_ok_reg, frame_err_reg;

    alu_op_t            op;
    logic [CH_W-1:0]    ch_field;
    logic [WIDTH-1:0]   a, b;
    logic               ch_ok;

    assign op       = alu_op_t'(mosi_sr_reg[F-1 -: 2]);
    assign ch_field = mosi_sr_reg[2*WIDTH +: CH_W];
    assign a        = mosi_sr_reg[WIDTH +: WIDTH];
    assign b        = mosi_sr_reg[0 +: WIDTH];
    assign ch_ok    = (32'(ch_field) < CHANNELS);

    logic [WIDTH:0] alu_wide;
    flags_t         alu_flags;

    always_comb begin
        alu_wide  = '0;
        alu_flags = '0;
        case (op)
            ADD:     alu_wide = {1'b0, a} + {1'b0, b};
            SUB:     alu_wide = {1'b0, a} - {1'b0, b};
            AND:     alu_wide = {1'b0, a & b};
            default: alu_wide = {1'b0, a | b};
        endcase
        // Bit WIDTH of the widened result is carry for ADD and borrow for SUB.
        alu_flags.z = (alu_wide[WIDTH-1:0] == '0);
        alu_flags.s = alu_wide[WIDTH-1];
        alu_flags.c = ((op == ADD) || (op == SUB)) && alu_wide[WIDTH];
        if (op == ADD)
            alu_flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_wide[WIDTH-1] != a[WIDTH-1]);
        else if (op == SUB)
            alu_flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_wide[WIDTH-1] != a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            mosi_sr_reg     <= '0;
            miso_sr_reg     <= '0;
            bit_cnt_reg     <= '0;
            result_reg      <= '0;
            last_result_reg <= '0;
            pend_flags_reg  <= '0;
            flags_reg       <= '0;
            frame_ok_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ss_fall) begin
                        miso_sr_reg <= {flags_reg, last_result_reg, {(F - RB_W){1'b0}}};
                        bit_cnt_reg <= '0;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        if (bit_cnt_reg == CNT_W'(F)) begin
                            state_reg <= EXEC;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end else begin
                        if (sclk_rise) begin
                            mosi_sr_reg <= {mosi_sr_reg[F-2:0], mosi_bit};
                            if (bit_cnt_reg != CNT_W'(F + 1)) bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                        if (sclk_fall) miso_sr_reg <= miso_sr_reg << 1;
                    end
                end
                EXEC: begin
                    result_reg     <= alu_wide[WIDTH-1:0];
                    pend_flags_reg <= alu_flags;
                    state_reg      <= WRITE;
                end
                WRITE: begin
                    if (ch_ok) begin
                        flags_reg       <= pend_flags_reg;
                        last_result_reg <= result_reg;
                        frame_ok_reg    <= 1'b1;
                    end else begin
                        frame_err_reg <= 1'b1;
                    end
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign MISO      = miso_sr_reg[F-1];
    assign flags     = flags_reg;
    assign frame_ok  = frame_ok_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);

    pwm_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_pwm_bank (
        .clk     (clk),
        .rst     (rst),
        .we      ((state_reg == WRITE) && ch_ok),
        .ch      (ch_field),
        .duty    (result_reg),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_spi_alu_pwm_ctrl.sv
// Randomised frames against a cycle-level behavioural model of the controller.
module tb_spi_alu_pwm_ctrl;

    localparam int W  = 4;
    localparam int F  = 11;
    localparam int F3 = 12;

    logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, ss = 1'b1, ss3 = 1'b1, mosi = 1'b0;
    logic miso, frame_ok, frame_err, busy;
    logic miso3, frame_ok3, frame_err3, busy3;
    logic [3:0] flags, flags3;
    logic [1:0] pwm_out;
    logic [2:0] pwm_out3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_alu_pwm_ctrl #(.WIDTH(W), .CHANNELS(2)) dut (
        .clk(clk), .rst(rst), .SCLK(sclk), .SS(ss), .MOSI(mosi), .MISO(miso),
        .flags(flags), .pwm_out(pwm_out), .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
    );

    spi_alu_pwm_ctrl #(.WIDTH(W), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .SCLK(sclk), .SS(ss3), .MOSI(mosi), .MISO(miso3),
        .flags(flags3), .pwm_out(pwm_out3), .frame_ok(frame_ok3), .frame_err(frame_err3), .busy(busy3)
    );

    typedef struct {
        bit         ok;
        int         ch;
        int         res;
        logic [3:0] fl;
    } exp_t;

    exp_t       exp_q[$];
    int         m_cnt;
    int         m_shadow[2];
    int         m_active[2];
    logic [3:0] m_flags;
    int         m_last;
    bit         rst_s;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t alu_model(input int op, input int ch, input int a, input int b, input int nch);
        exp_t e;
        int r, sa, sb, sr;
        bit c, v;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        c = 0;
        v = 0;
        case (op)
            0: begin r = a + b; c = (r > 15); sr = sa + sb; v = (sr > 7) || (sr < -8); end
            1: begin r = a - b; c = (a < b);  sr = sa - sb; v = (sr > 7) || (sr < -8); end
            2: r = a & b;
            default: r = a | b;
        endcase
        r = r & 15;
        e.ok  = (ch < nch);
        e.ch  = ch;
        e.res = r;
        e.fl  = {r == 0, c, v, r >= 8};
        return e;
    endfunction

    // Model: counter wraps every 16 cycles, active duty reloads on the wrap,
    // committed frames write the shadow duty of their channel.
    initial begin
        logic [1:0] pexp;
        exp_t e;
        forever begin
            @(posedge clk);
            rst_s = rst;
            @(negedge clk);
            pexp = '0;
            if (rst_s) begin
                m_cnt = 0;
                m_flags = '0;
                m_last = 0;
                for (int i = 0; i < 2; i++) begin
                    m_shadow[i] = 0;
                    m_active[i] = 0;
                end
                exp_q.delete();
                check("reset_outputs", {frame_ok, frame_err, busy, miso}, 4'b0000);
            end else begin
                for (int i = 0; i < 2; i++) pexp[i] = (m_cnt < m_active[i]);
                if (m_cnt == 15)
                    for (int i = 0; i < 2; i++) m_active[i] = m_shadow[i];
                m_cnt = (m_cnt + 1) % 16;
                if (frame_ok || frame_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", {frame_ok, frame_err}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_kind", {frame_ok, frame_err}, e.ok ? 2'b10 : 2'b01);
                        if (e.ok) begin
                            m_shadow[e.ch] = e.res;
                            m_flags = e.fl;
                            m_last = e.res;
                        end
                    end
                end
            end
            check("pwm_out", pwm_out, pexp);
            check("flags", flags, m_flags);
        end
    end

    task automatic run_frame(input int op, input int ch, input int a, input int b, input int nbits,
                             input bit to3, input int rst_at, input int align, output logic [31:0] cap);
        logic [31:0] stream, want, mask;
        logic [3:0]  lr;
        exp_t        e;
        int          fl, chw, nch;
        fl  = to3 ? F3 : F;
        chw = to3 ? 2 : 1;
        nch = to3 ? 3 : 2;
        stream = (32'(op) << (chw + 2 * W)) | (32'(ch) << (2 * W)) | (32'(a) << W) | 32'(b);
        stream = stream << (32 - fl);
        lr   = m_last[3:0];
        want = {m_flags, lr, 24'b0};
        mask = 32'hFFFF_FFFF << (32 - nbits);
        e = alu_model(op, ch, a, b, nch);
        if (nbits != fl) e.ok = 0;
        cap = '0;

        @(negedge clk);
        if (to3) ss3 = 1'b0; else ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            mosi = stream[31-i];
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            cap[31-i] = to3 ? miso3 : miso;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        if (!to3 && rst_at < 0) check("miso_stream", cap & mask, want & mask);

        if (align >= 0)
            for (int k = 0; k < 20 && m_cnt != align; k++) @(negedge clk);
        if (!to3 && rst_at < 0) exp_q.push_back(e);
        if (to3) ss3 = 1'b1; else ss = 1'b1;

        if (to3) begin
            for (int k = 0; k < 20 && !(frame_ok3 || frame_err3); k++) @(negedge clk);
            check("dut3_pulse", {frame_ok3, frame_err3}, e.ok ? 2'b10 : 2'b01);
        end else begin
            for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
            check("commit_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic count_high(input int idx, output int hi);
        hi = 0;
        repeat (40) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (pwm_out[idx]) hi++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap;
        int hi, pick, nbits, align;

        repeat (3) @(negedge clk);
        check("reset_state", {flags, pwm_out, miso, busy, frame_ok, frame_err}, 10'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run_frame(0, 0, 9, 8, F, 0, -1, -1, cap);
        check("add_flags", flags, 4'b0110);
        count_high(0, hi);
        check("add_duty_high", hi, 1);

        run_frame(1, 1, 3, 3, F, 0, -1, -1, cap);
        check("readback_miso", cap[31:21], 11'b01100001000);
        check("sub_flags", flags, 4'b1000);
        count_high(1, hi);
        check("sub_duty_high", hi, 0);

        run_frame(2, 0, 15, 15, 10, 0, -1, -1, cap);
        check("short_frame_flags", flags, 4'b1000);
        count_high(0, hi);
        check("short_frame_duty", hi, 1);

        run_frame(3, 0, 12, 3, F, 0, -1, 0, cap);
        check("or_flags", flags, 4'b0001);
        count_high(0, hi);
        check("duty15_high", hi, 15);

        run_frame(0, 1, 2, 3, F, 0, -1, 10, cap);
        count_high(1, hi);
        check("wrap_write_duty", hi, 5);

        for (int n = 0; n < 16; n++) begin
            pick  = $urandom_range(0, 5);
            nbits = (pick == 4) ? 10 : (pick == 5) ? 12 : F;
            align = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : -1;
            run_frame($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 15),
                      $urandom_range(0, 15), nbits, 0, -1, align, cap);
        end

        run_frame(0, 0, 1, 1, F, 0, 6, -1, cap);
        check("rst_mid_frame_flags", flags, 4'b0000);
        check("rst_mid_frame_pwm", pwm_out, 2'b00);

        run_frame(3, 1, 5, 10, F, 0, -1, -1, cap);
        check("post_reset_flags", flags, 4'b0001);

        run_frame(0, 2, 5, 4, F3, 1, -1, -1, cap);
        check("dut3_commit_flags", flags3, 4'b0011);
        run_frame(0, 3, 1, 1, F3, 1, -1, -1, cap);
        check("dut3_bad_ch_flags", flags3, 4'b0011);
        repeat (40) @(negedge clk);
        check("dut3_bad_ch_pwm0", pwm_out3[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
